// File: rtl/regfile_operand_fetch_if.sv
// Operand-fetch bus bundle: decode request, writeback commit, register file
// ports and the execute-side operand handshake. The slave modport is the
// sequencer's view; the master modport is the surrounding pipeline's view.
interface regfile_operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int INFO_W = 32
);

  // decode read request
  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_rs1;
  logic [ADDR_W-1:0] dec_rs2;
  logic [INFO_W-1:0] dec_info;

  // writeback commit
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  // register file ports (A is shared read/write, B is read-only)
  logic [ADDR_W-1:0] rf_address_a;
  logic [ADDR_W-1:0] rf_address_b;
  logic [DATA_W-1:0] rf_in_a;
  logic              rf_wren_a;
  logic [DATA_W-1:0] rf_out_a;
  logic [DATA_W-1:0] rf_out_b;

  // operand bundle towards execute
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_rs1_data;
  logic [DATA_W-1:0] op_rs2_data;
  logic [INFO_W-1:0] op_info;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_info,
    input  wb_valid, wb_rd, wb_data,
    input  rf_out_a, rf_out_b,
    input  op_ready,
    output dec_ready, wb_ready,
    output rf_address_a, rf_address_b, rf_in_a, rf_wren_a,
    output op_valid, op_rs1_data, op_rs2_data, op_info
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_info,
    output wb_valid, wb_rd, wb_data,
    output rf_out_a, rf_out_b,
    output op_ready,
    input  dec_ready, wb_ready,
    input  rf_address_a, rf_address_b, rf_in_a, rf_wren_a,
    input  op_valid, op_rs1_data, op_rs2_data, op_info
  );

endinterface

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch / writeback sequencer in front of a 32x32 register file.
// Port A is shared between writeback commits (always preferred) and rs1
// reads; port B reads rs2. The register file read data arrives one cycle
// after the address, so an accepted request spends one cycle in READ before
// the bundle is presented in HOLD. Writebacks that land while the bundle is
// in flight are forwarded into the held operand values.
module regfile_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int INFO_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  regfile_operand_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] rs1_reg;
  logic [ADDR_W-1:0] rs2_reg;
  logic [INFO_W-1:0] info_reg;
  logic [DATA_W-1:0] rs1_data_reg;
  logic [DATA_W-1:0] rs2_data_reg;
  logic              valid_reg;

  logic              commit;
  logic              dec_ready_int;
  logic              accept;
  logic              fwd_window;
  logic              fwd_rs1;
  logic              fwd_rs2;
  logic [DATA_W-1:0] rf_rs1_val;
  logic [DATA_W-1:0] rf_rs2_val;

  // Handshake decisions: writeback always wins port A, decode only gets in
  // when no writeback is pending and there is somewhere for the bundle to go.
  always_comb begin
    commit        = bus.wb_valid & ~rst;
    dec_ready_int = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE:    dec_ready_int = ~bus.wb_valid;
        HOLD:    dec_ready_int = bus.op_ready & ~bus.wb_valid;
        default: dec_ready_int = 1'b0;
      endcase
    end
    accept = bus.dec_valid & dec_ready_int;
  end

  // Forwarding applies in READ and in HOLD while the bundle stays put; on the
  // handoff cycle the write only reaches the register file.
  always_comb begin
    fwd_window = (state_reg == READ) || ((state_reg == HOLD) && !bus.op_ready);
    fwd_rs1    = commit && fwd_window && (bus.wb_rd != '0) && (bus.wb_rd == rs1_reg);
    fwd_rs2    = commit && fwd_window && (bus.wb_rd != '0) && (bus.wb_rd == rs2_reg);
    // x0 reads as zero regardless of what the register file returns
    rf_rs1_val = (rs1_reg == '0) ? '0 : bus.rf_out_a;
    rf_rs2_val = (rs2_reg == '0) ? '0 : bus.rf_out_b;
  end

  // Register file port steering: commit address, then new read, else the
  // held indices so the array sees stable addresses when idle.
  always_comb begin
    bus.rf_wren_a    = commit;
    bus.rf_in_a      = bus.wb_data;
    bus.rf_address_a = rs1_reg;
    bus.rf_address_b = rs2_reg;
    if (commit) begin
      bus.rf_address_a = bus.wb_rd;
    end else if (accept) begin
      bus.rf_address_a = bus.dec_rs1;
      bus.rf_address_b = bus.dec_rs2;
    end
  end

  // Sequencer state, held request and operand bundle registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      info_reg     <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          valid_reg <= 1'b0;
          if (accept) begin
            rs1_reg   <= bus.dec_rs1;
            rs2_reg   <= bus.dec_rs2;
            info_reg  <= bus.dec_info;
            state_reg <= READ;
          end
        end
        READ: begin
          rs1_data_reg <= fwd_rs1 ? bus.wb_data : rf_rs1_val;
          rs2_data_reg <= fwd_rs2 ? bus.wb_data : rf_rs2_val;
          valid_reg    <= 1'b1;
          state_reg    <= HOLD;
        end
        HOLD: begin
          if (bus.op_ready) begin
            valid_reg <= 1'b0;
            if (accept) begin
              rs1_reg   <= bus.dec_rs1;
              rs2_reg   <= bus.dec_rs2;
              info_reg  <= bus.dec_info;
              state_reg <= READ;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            if (fwd_rs1) rs1_data_reg <= bus.wb_data;
            if (fwd_rs2) rs2_data_reg <= bus.wb_data;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.dec_ready   = dec_ready_int;
  assign bus.wb_ready    = ~rst;
  assign bus.op_valid    = valid_reg;
  assign bus.op_rs1_data = rs1_data_reg;
  assign bus.op_rs2_data = rs2_data_reg;
  assign bus.op_info     = info_reg;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: directed scenarios followed by random
// traffic. A behavioural register file sits on the rf ports; the reference
// model is an architectural register array plus a queue of accepted requests.
// A bundle handed to execute must carry the architectural values as they stood
// before that cycle's writeback, and must appear two cycles after its accept.
module tb_regfile_operand_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_operand_fetch_if bus ();

  regfile_operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // behavioural register file: registered reads, x0 writes dropped
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (bus.rf_wren_a && bus.rf_address_a != 5'd0) rf_mem[bus.rf_address_a] <= bus.rf_in_a;
    bus.rf_out_a <= rf_mem[bus.rf_address_a];
    bus.rf_out_b <= rf_mem[bus.rf_address_b];
  end

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] info;
    int          cyc;
  } req_t;

  req_t        pend_q[$];
  logic [31:0] arch [32];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_cons = 0;
  int          cyc = 0;
  logic        prev_valid = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_info = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock of stimulus plus all per-cycle checks and model updates
  task automatic drive(input logic r, input logic wv, input logic [4:0] rd, input logic [31:0] wd,
                       input logic dv, input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] inf, input logic ordy);
    req_t e;
    @(negedge clk);
    rst = r;
    bus.wb_valid = wv; bus.wb_rd = rd; bus.wb_data = wd;
    bus.dec_valid = dv; bus.dec_rs1 = a; bus.dec_rs2 = b; bus.dec_info = inf;
    bus.op_ready = ordy;
    #1;
    chk("wb_ready", bus.wb_ready, !r);
    chk("rf_wren", bus.rf_wren_a, wv && !r);
    if (wv && !r) begin
      chk("rf_wr_addr", bus.rf_address_a, rd);
      chk("rf_wr_data", bus.rf_in_a, wd);
    end
    if (r || wv) chk("dec_ready_blocked", bus.dec_ready, 1'b0);
    else if (bus.op_valid && !ordy) chk("dec_ready_held", bus.dec_ready, 1'b0);
    if (!r && dv && bus.dec_ready) begin
      chk("rd_addr_a", bus.rf_address_a, a);
      chk("rd_addr_b", bus.rf_address_b, b);
    end
    if (!r && prev_hold) begin
      chk("hold_valid", bus.op_valid, 1'b1);
      chk("hold_info", bus.op_info, prev_info);
    end
    if (!r && bus.op_valid && !prev_valid) begin
      if (pend_q.size() == 0) chk("orphan_valid", 1'b1, 1'b0);
      else chk("latency", cyc - pend_q[0].cyc, 2);
    end
    if (!r && bus.op_valid && ordy) begin
      n_cons++;
      if (pend_q.size() == 0) begin
        chk("orphan_bundle", 1'b1, 1'b0);
      end else begin
        e = pend_q.pop_front();
        chk("op_rs1", bus.op_rs1_data, arch[e.rs1]);
        chk("op_rs2", bus.op_rs2_data, arch[e.rs2]);
        chk("op_info", bus.op_info, e.info);
      end
    end
    if (!r && dv && bus.dec_ready) begin
      e.rs1 = a; e.rs2 = b; e.info = inf; e.cyc = cyc;
      pend_q.push_back(e);
    end
    if (!r && wv && rd != 5'd0) arch[rd] = wd;
    if (r) pend_q.delete();
    prev_hold  = !r && bus.op_valid && !ordy;
    prev_valid = bus.op_valid;
    prev_info  = bus.op_info;
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 32'd0, ordy);
  endtask

  logic [31:0] s_rs1, s_rs2, s_info;
  int          cons0;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = '0;
      arch[i]   = '0;
    end
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_info = 0;
    bus.op_ready = 0;

    // reset state
    drive(1'b1, 1'b1, 5'd4, 32'h1, 1'b1, 5'd1, 5'd2, 32'h3, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    chk("rst_op_valid", bus.op_valid, 1'b0);
    chk("rst_op_rs1", bus.op_rs1_data, 32'h0);
    chk("rst_op_rs2", bus.op_rs2_data, 32'h0);
    chk("rst_op_info", bus.op_info, 32'h0);

    // 1: writeback then dependent read
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'hA5, 1'b0);
    chk("t1_accept", bus.dec_ready, 1'b1);
    idle(1'b0);
    chk("t1_not_yet", bus.op_valid, 1'b0);
    idle(1'b0);
    chk("t1_valid", bus.op_valid, 1'b1);
    chk("t1_rs1", bus.op_rs1_data, 32'hDEADBEEF);
    chk("t1_rs2", bus.op_rs2_data, 32'h0);
    chk("t1_info", bus.op_info, 32'hA5);
    idle(1'b1);

    // 2: simultaneous wb and dec in IDLE
    drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 5'd0, 32'h22, 1'b0);
    chk("t2_wb_ready", bus.wb_ready, 1'b1);
    chk("t2_dec_starved", bus.dec_ready, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 32'h22, 1'b0);
    chk("t2_dec_ready", bus.dec_ready, 1'b1);
    idle(1'b0);
    idle(1'b0);
    chk("t2_rs1", bus.op_rs1_data, 32'h11);
    idle(1'b1);

    // 3: forwarding in READ, then in HOLD with op_ready low
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 32'h77, 1'b0);
    drive(1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    idle(1'b0);
    chk("t3_read_rs1", bus.op_rs1_data, 32'h1234);
    chk("t3_read_rs2", bus.op_rs2_data, 32'h1234);
    idle(1'b1);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 32'h78, 1'b0);
    idle(1'b0);
    idle(1'b0);
    drive(1'b0, 1'b1, 5'd7, 32'h5678, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    idle(1'b0);
    chk("t3_hold_rs1", bus.op_rs1_data, 32'h5678);
    chk("t3_hold_rs2", bus.op_rs2_data, 32'h5678);
    idle(1'b1);

    // 4: x0 is never written nor forwarded
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 32'h40, 1'b0);
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    idle(1'b0);
    chk("t4_rs1_zero", bus.op_rs1_data, 32'h0);
    chk("t4_rs2_zero", bus.op_rs2_data, 32'h0);
    idle(1'b1);

    // 5: stall for 5 cycles, then back-to-back throughput
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd3, 32'h55, 1'b0);
    idle(1'b0);
    idle(1'b0);
    s_rs1 = bus.op_rs1_data; s_rs2 = bus.op_rs2_data; s_info = bus.op_info;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2, 32'h66, 1'b0);
      chk("t5_valid", bus.op_valid, 1'b1);
      chk("t5_dec_ready", bus.dec_ready, 1'b0);
      chk("t5_rs1", bus.op_rs1_data, s_rs1);
      chk("t5_rs2", bus.op_rs2_data, s_rs2);
      chk("t5_info", bus.op_info, s_info);
    end
    cons0 = n_cons;
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i % 8), 5'((i + 3) % 8), 32'(i), 1'b1);
    chk("t5_throughput", n_cons - cons0, 10);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // 6: reset while a bundle is held
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7, 32'h99, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("t6_holding", bus.op_valid, 1'b1);
    drive(1'b1, 1'b1, 5'd9, 32'hBAD0BAD0, 1'b1, 5'd1, 5'd1, 32'h1, 1'b0);
    chk("t6_no_write", bus.rf_wren_a, 1'b0);
    idle(1'b0);
    chk("t6_valid_clr", bus.op_valid, 1'b0);
    chk("t6_rs1_clr", bus.op_rs1_data, 32'h0);
    chk("t6_rs2_clr", bus.op_rs2_data, 32'h0);
    chk("t6_info_clr", bus.op_info, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5, 32'hC6, 1'b0);
    chk("t6_accept", bus.dec_ready, 1'b1);
    idle(1'b0);
    idle(1'b0);
    chk("t6_rs1_unwritten", bus.op_rs1_data, 32'h0);
    chk("t6_rs2", bus.op_rs2_data, 32'hDEADBEEF);
    idle(1'b1);

    // random traffic, small index range to provoke forwarding hazards
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
